cpri_txdata_pack: RTL

- Transmit-side counterpart of cpri_rxdata_unpack. Accepts per-RE 4-antenna IQ samples (4 x 32 bit) with address, valid and last.
- Buffers the samples in a small FIFO and serialises each RE into two 64-bit CPRI IQ words, tagged with a 0..95 sequence number.
- Sits between the antenna-side buffer and the CPRI transmit framer. Its output is bit-compatible with what cpri_rxdata_unpack consumes.

---
 rtl/params_list_pkg.sv | 19 +
 rtl/cpri_pack_fifo.sv | 52 +++++
 rtl/cpri_txdata_pack.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/params_list_pkg.sv
// Shared constants and types for the CPRI IQ pack/unpack pair.
package params_list_pkg;

  localparam int CPRI_SEQ_MAX   = 95;
  localparam int NUM_RE_PER_SYM = 1584;
  localparam int IQ_ANT_W       = 32;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_ant_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } pack_state_e;

endpackage

// File: rtl/cpri_pack_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on o_rdata.
module cpri_pack_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic [CW-1:0] o_count_nxt
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok  = i_push && (count_q != CW'(DEPTH));
    pop_ok   = i_pop && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata     = mem_q[rd_ptr_q];
  assign o_empty     = (count_q == '0);
  assign o_count_nxt = count_d;

endmodule

// File: rtl/cpri_txdata_pack.sv
// Packs 4-antenna RE samples into pairs of 64-bit CPRI IQ words with a 0..SEQ_MAX tag.
// Optional symbol/word statistics outputs are built when CPRI_PACK_STAT_EN is defined.
module cpri_txdata_pack
  import params_list_pkg::*;
#(
  parameter int ANT        = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_RE     = NUM_RE_PER_SYM,
  parameter int SEQ_MAX    = CPRI_SEQ_MAX,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [ADDR_WIDTH-1:0]      i_iq_addr,
  input  logic [ANT-1:0][31:0]       i_iq_data,
  input  logic                       i_iq_vld,
  input  logic                       i_iq_last,
  output logic                       o_iq_ready,
  input  logic                       i_tx_enable,
  output logic [63:0]                o_cpri_data,
  output logic [6:0]                 o_cpri_seq,
  output logic                       o_cpri_vld,
  output logic                       o_cpri_last,
  input  logic                       i_clr_err,
  output logic                       o_ovf,
`ifdef CPRI_PACK_STAT_EN
  output logic [15:0]                o_sym_cnt,
  output logic [31:0]                o_word_cnt,
`endif
  output logic                       o_addr_err
);

  localparam int HALF = ANT * IQ_ANT_W / 2;
  localparam int EW   = 2 * HALF + 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  pack_state_e           state_q, state_d;
  logic [EW-1:0]         hold_q, hold_d, fifo_rdata;
  logic [6:0]            seq_q, seq_d;
  logic                  ready_q, ready_d, ovf_q, ovf_d, aerr_q, aerr_d;
  logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
  logic [CW-1:0]         fifo_count_nxt;
  logic                  push, pop, fifo_empty, addr_bad;
  logic                  word_vld, word_last;
  logic [HALF-1:0]       word;

  assign push = i_iq_vld && ready_q;

  cpri_pack_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (push),
    .i_wdata     ({i_iq_last, i_iq_data}),
    .i_pop       (pop),
    .o_rdata     (fifo_rdata),
    .o_empty     (fifo_empty),
    .o_count_nxt (fifo_count_nxt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_tx_enable) begin
      case (state_q)
        IDLE:    if (!fifo_empty) state_d = LO;
        LO:      state_d = HI;
        HI:      state_d = fifo_empty ? IDLE : LO;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop       = 1'b0;
    word_vld  = 1'b0;
    word_last = 1'b0;
    word      = hold_q[HALF-1:0];
    case (state_q)
      IDLE: pop = i_tx_enable && !fifo_empty;
      LO:   word_vld = i_tx_enable;
      HI: begin
        word_vld  = i_tx_enable;
        word      = hold_q[2*HALF-1:HALF];
        word_last = i_tx_enable && hold_q[2*HALF];
        pop       = i_tx_enable && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    hold_d = pop ? fifo_rdata : hold_q;
    seq_d  = seq_q;
    // A symbol's last word restarts the tag at 0 even mid-wrap.
    if (word_vld) seq_d = (word_last || seq_q == 7'(SEQ_MAX)) ? 7'd0 : seq_q + 7'd1;
    ready_d    = (fifo_count_nxt <= CW'(FIFO_DEPTH - 2));
    addr_bad   = push && ((i_iq_addr != exp_addr_q) || (i_iq_addr >= ADDR_WIDTH'(NUM_RE)));
    exp_addr_d = exp_addr_q;
    if (push) exp_addr_d = i_iq_last ? '0 : i_iq_addr + ADDR_WIDTH'(1);
    ovf_d  = (ovf_q && !i_clr_err) || (i_iq_vld && !ready_q);
    aerr_d = (aerr_q && !i_clr_err) || addr_bad;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_q     <= '0;
      seq_q      <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      aerr_q     <= 1'b0;
      exp_addr_q <= '0;
    end else begin
      hold_q     <= hold_d;
      seq_q      <= seq_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      aerr_q     <= aerr_d;
      exp_addr_q <= exp_addr_d;
    end
  end

`ifdef CPRI_PACK_STAT_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    sym_cnt_d  = sym_cnt_q + 16'(word_last);
    word_cnt_d = word_cnt_q + 32'(word_vld);
    if (i_clr_err) begin
      sym_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sym_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_sym_cnt  = sym_cnt_q;
  assign o_word_cnt = word_cnt_q;
`endif

  assign o_iq_ready  = ready_q;
  assign o_cpri_vld  = word_vld;
  assign o_cpri_data = word_vld ? word : '0;
  assign o_cpri_last = word_last;
  assign o_cpri_seq  = seq_q;
  assign o_ovf       = ovf_q;
  assign o_addr_err  = aerr_q;

endmodule
